reservoir_ring: RTL
===================

# reservoir_ring

Parametrised integer echo-state reservoir with handshakes: `RES_SIZE` signed neurons in a cyclic-shift ring with configurable jump. Each accepted bipolar input word updates all neurons in one cycle with clipped integer arithmetic. Outputs are suppressed until a washout count has elapsed, with valid/ready flow control on both sides. The block sits between the input encoder and the readout layer and is the successor to the fixed 3×3 reservoir ring.

## Interface

- `RES_SIZE`, 8: number of neurons, ≥2.
- `DATA_WIDTH`, 4: signed two's-complement width of each neuron state.
- `KAPPA`, 3: clipping threshold, 1 ≤ KAPPA ≤ 2^(DATA_WIDTH-1)-1.
- `SHIFT`, 1: ring jump, 1 ≤ SHIFT ≤ RES_SIZE-1; neuron i is fed from neuron (i-SHIFT) mod RES_SIZE.
- `WASHOUT`, 4: accepted inputs discarded after reset/clear before outputs are flagged valid; 0 is legal.
- `iClk` input 1: single clock, rising edge.
- `iRst` input 1: asynchronous, active-high reset.
- `iClear` input 1: synchronous state clear.
- `iWord` input RES_SIZE: bipolar input; bit i = 1 means +1 to neuron i, 0 means −1.
- `iValid` input 1: iWord valid.
- `oReady` output 1: block can accept iWord this cycle.
- `oOut` output DATA_WIDTH*RES_SIZE: neuron states; neuron i at `oOut[i*DATA_WIDTH +: DATA_WIDTH]`.
- `oValid` output 1: oOut holds a fresh post-washout sample.
- `iReady` input 1: downstream accepts oOut.
- `oWashDone` output 1: washout complete.

## Operation

- State: `x[0..RES_SIZE-1]` signed registers, washout counter `cnt` (width clog2(WASHOUT+1)), `oValid` register, FSM {WASH, RUN}.
- `oOut` is the direct concatenation of `x`. `oWashDone` = (state == RUN).
- `oReady = !iClear && (!oValid || iReady)`. Accept = iValid && oReady.
- On accept, for all i simultaneously:
  - `s = x[(i-SHIFT) mod RES_SIZE] + (iWord[i] ? +1 : -1)`, evaluated at DATA_WIDTH+1 bits signed.
  - `x[i] = s > KAPPA ? KAPPA : s < -KAPPA ? -KAPPA : s`. No wrap-around is allowed.
- FSM WASH: each accept increments `cnt`; when an accept occurs with `cnt == WASHOUT-1`, go to RUN. Outputs produced in WASH never set oValid.
- If WASHOUT = 0, reset/clear enters RUN directly.
- FSM RUN: each accept sets oValid = 1 on the same edge; `cnt` holds.
- oValid clears on an edge where `oValid && iReady && !accept`. Accept while `oValid && iReady` keeps oValid = 1 (back-to-back).
- iClear (priority over accept; no input is consumed): x = 0, cnt = 0, oValid = 0, state = WASH (RUN if WASHOUT = 0).
- iRst applies the same values asynchronously; assertion mid-update discards the in-flight update.
- State holds whenever there is no accept, including under backpressure (oValid = 1, iReady = 0).

## Timing

- Reset values: oOut = 0, oValid = 0, oWashDone = (WASHOUT == 0), oReady = 1 once iRst is low (if iClear = 0).
- Latency: x, oValid and oWashDone update on the accepting edge and are visible the following cycle.
- Throughput: 1 word/cycle when iReady is held high.
- oReady is combinational from oValid, iReady and iClear. There is no combinational path from iValid to any output.
- oOut is stable while oValid = 1 and iReady = 0.

## Test plan

- Reset/clip, with RES_SIZE=3, DATA_WIDTH=3, KAPPA=3, SHIFT=1, WASHOUT=2: pulse iRst → oOut=0, oValid=0, oWashDone=0, oReady=1. Feed iWord=3'b111 ×4 with iReady=1 → states {1,1,1}, {2,2,2}, {3,3,3}, {3,3,3}. oValid first high after the 3rd accept; oWashDone high after the 2nd.
- Rotation, same params, from reset: 3'b001 → x={1,−1,−1} (x0,x1,x2); then 3'b000 → x={−2,0,−2}. With SHIFT=2 from reset: 3'b001 then 3'b000 → x={−2,−2,0}.
- Negative clip: 3'b000 ×5 from reset → each lane reads 3'b101 (−3) and never wraps to positive.
- Backpressure: in RUN, hold iReady=0 with iValid=1 → oReady=0, oOut and x frozen for 5 cycles. Release iReady → exactly one accept per cycle, no sample lost or duplicated.
- Clear priority: iClear=1 with iValid=1 in RUN → no accept, next cycle oOut=0, oValid=0, oWashDone=0. WASHOUT accepts are again required before oValid.
- Async reset mid-stream: assert iRst between clock edges during back-to-back accepts → outputs go to reset values immediately without waiting for a clock. Same for WASHOUT=0, where oWashDone=1 at reset and the first accept sets oValid.

Source files
------------

// File: rtl/reservoir_ring.sv
// Integer echo-state reservoir: RES_SIZE clipped signed neurons in a shifted ring,
// with washout gating and valid/ready handshakes on both sides.
module reservoir_ring #(
    parameter int RES_SIZE   = 8,
    parameter int DATA_WIDTH = 4,
    parameter int KAPPA      = 3,
    parameter int SHIFT      = 1,
    parameter int WASHOUT    = 4
) (
    input  logic                           iClk,
    input  logic                           iRst,
    input  logic                           iClear,
    input  logic [RES_SIZE-1:0]            iWord,
    input  logic                           iValid,
    output logic                           oReady,
    output logic [DATA_WIDTH*RES_SIZE-1:0] oOut,
    output logic                           oValid,
    input  logic                           iReady,
    output logic                           oWashDone
);

    localparam int CW = (WASHOUT > 0) ? $clog2(WASHOUT + 1) : 1;
    localparam int SW = DATA_WIDTH + 1;
    localparam logic signed [SW-1:0] KAPPA_P  = SW'(KAPPA);
    localparam logic signed [SW-1:0] KAPPA_N  = -KAPPA_P;
    localparam logic [CW-1:0]        CNT_LAST = (WASHOUT > 0) ? CW'(WASHOUT - 1) : {CW{1'b0}};

    typedef enum logic [0:0] {
        ST_WASH = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t ST_INIT = (WASHOUT == 0) ? ST_RUN : ST_WASH;

    logic [DATA_WIDTH-1:0] r_x      [RES_SIZE];
    logic [DATA_WIDTH-1:0] w_x_next [RES_SIZE];
    logic [CW-1:0]         r_cnt;
    logic                  r_valid;
    state_t                r_state;
    state_t                w_state_next;
    logic                  w_accept;
    logic                  w_wash_done;

    // Sum is formed one bit wider than the state so saturation never sees a wrapped value.
    function automatic logic [DATA_WIDTH-1:0] clip_step(input logic [DATA_WIDTH-1:0] x,
                                                        input logic b);
        logic signed [SW-1:0] s;
        s = $signed({x[DATA_WIDTH-1], x});
        if (b) s = s + SW'(1);
        else   s = s - SW'(1);
        if (s > KAPPA_P)      s = KAPPA_P;
        else if (s < KAPPA_N) s = KAPPA_N;
        else                  s = s;
        return s[DATA_WIDTH-1:0];
    endfunction

    assign oReady   = !iClear && (!r_valid || iReady);
    assign w_accept = iValid && oReady;
    assign oValid   = r_valid;
    assign oWashDone = w_wash_done;

    for (genvar gi = 0; gi < RES_SIZE; gi++) begin : g_neuron
        localparam int SRC = (gi + RES_SIZE - SHIFT) % RES_SIZE;
        assign w_x_next[gi] = clip_step(r_x[SRC], iWord[gi]);
        assign oOut[gi*DATA_WIDTH +: DATA_WIDTH] = r_x[gi];
    end

    // Neuron states, washout counter and output-valid flag.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < RES_SIZE; i++) r_x[i] <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (iClear) begin
            for (int i = 0; i < RES_SIZE; i++) r_x[i] <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            for (int i = 0; i < RES_SIZE; i++) r_x[i] <= w_x_next[i];
            if (r_state == ST_WASH) r_cnt <= r_cnt + CW'(1);
            r_valid <= (r_state == ST_RUN);
        end else if (r_valid && iReady) begin
            r_valid <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) r_state <= ST_INIT;
        else      r_state <= w_state_next;
    end

    // FSM next state: washout ends on the accept that brings the count to WASHOUT.
    always_comb begin
        w_state_next = r_state;
        if (iClear)
            w_state_next = ST_INIT;
        else if (w_accept && (r_state == ST_WASH) && (r_cnt == CNT_LAST))
            w_state_next = ST_RUN;
        else
            w_state_next = r_state;
    end

    // FSM outputs.
    always_comb begin
        w_wash_done = (r_state == ST_RUN);
    end

endmodule
